// File: rtl/orv64_typedef_pkg.sv
// rtl/orv64_typedef_pkg.sv - shared types and constants for the orv64 debug trigger unit
package orv64_typedef_pkg;

    localparam int ORV64_TRIG_MAX   = 8;
    localparam int ORV64_TRIG_IDX_W = $clog2(ORV64_TRIG_MAX);

    typedef enum logic [1:0] {
        ORV64_TRIG_RUN  = 2'd0,
        ORV64_TRIG_HALT = 2'd1,
        ORV64_TRIG_SKIP = 2'd2
    } orv64_trig_state_e;

    typedef enum logic [1:0] {
        ORV64_TRIG_SRC_IF      = 2'd0,
        ORV64_TRIG_SRC_WB      = 2'd1,
        ORV64_TRIG_SRC_INSTRET = 2'd2
    } orv64_trig_src_e;

endpackage

// File: rtl/orv64_trig_cmp.sv
// rtl/orv64_trig_cmp.sv - one masked PC comparator with a saturating hit counter
module orv64_trig_cmp
    import orv64_typedef_pkg::*;
#(
    parameter int VADDR_W = 39,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [VADDR_W-1:0] pc_i,
    input  logic               valid_i,
    input  logic               en_i,
    input  logic [VADDR_W-1:0] addr_i,
    input  logic [VADDR_W-1:0] mask_i,
    input  logic               cnt_inc_en_i,
    input  logic               cnt_clr_i,
    output logic               hit_o,
    output logic [CNT_W-1:0]   cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Mask bit 1 means the bit is compared; an all-zero mask hits every valid PC.
    always_comb begin
        hit_o = valid_i & en_i & (((pc_i ^ addr_i) & mask_i) == '0);
    end

    // Clear wins over increment; the counter sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (cnt_inc_en_i && hit_o && (cnt_q != '1)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/orv64_trigger_unit.sv
// rtl/orv64_trigger_unit.sv - fetch/writeback/instret debug triggers with halt and resume
module orv64_trigger_unit
    import orv64_typedef_pkg::*;
#(
    parameter int N_IF    = 4,
    parameter int N_WB    = 4,
    parameter int VADDR_W = 39,
    parameter int DATA_W  = 64,
    parameter int CNT_W   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_IF*VADDR_W-1:0]       if_trig_addr,
    input  logic [N_IF*VADDR_W-1:0]       if_trig_mask,
    input  logic [N_IF-1:0]               if_trig_en,
    input  logic [N_WB*VADDR_W-1:0]       wb_trig_addr,
    input  logic [N_WB*VADDR_W-1:0]       wb_trig_mask,
    input  logic [N_WB-1:0]               wb_trig_en,
    input  logic                          instret_bp_en,
    input  logic [DATA_W-1:0]             instret_bp,
    input  logic [VADDR_W-1:0]            if_pc,
    input  logic [VADDR_W-1:0]            wb_pc,
    input  logic                          if_valid,
    input  logic                          wb_valid,
    input  logic [DATA_W-1:0]             minstret,
    input  logic                          resume_req,
    output logic                          resume_ack,
    input  logic                          cnt_clr,
    output logic                          bp_stall,
    output logic                          halted,
    output logic                          cause_vld,
    output logic [1:0]                    cause_src,
    output logic [2:0]                    cause_idx,
    output logic [(N_IF+N_WB)*CNT_W-1:0]  hit_cnt
);

    logic                        dff_if_valid_q;
    logic                        dff_wb_valid_q;
    logic [VADDR_W-1:0]          dff_if_pc_q;
    logic [VADDR_W-1:0]          dff_wb_pc_q;
    logic                        rff_instret_hit_q;
    logic                        if_pc_load;
    logic                        wb_pc_load;

    logic [N_IF-1:0]             if_hit;
    logic [N_WB-1:0]             wb_hit;
    logic                        any_hit;

    orv64_trig_state_e           state_q;
    orv64_trig_state_e           state_d;
    logic                        cause_load;
    logic                        cnt_inc_en;

    orv64_trig_src_e             hit_src;
    logic [ORV64_TRIG_IDX_W-1:0] hit_idx;
    logic                        cause_vld_q;
    orv64_trig_src_e             cause_src_q;
    logic [ORV64_TRIG_IDX_W-1:0] cause_idx_q;

    // PC flops only toggle when some trigger could use them (stands in for the ICG enable).
    assign if_pc_load = if_valid & (|if_trig_en);
    assign wb_pc_load = wb_valid & (|wb_trig_en);

    // Pipeline sample stage: valids every cycle, PCs gated, instret compare registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            dff_if_valid_q    <= 1'b0;
            dff_wb_valid_q    <= 1'b0;
            dff_if_pc_q       <= '0;
            dff_wb_pc_q       <= '0;
            rff_instret_hit_q <= 1'b0;
        end else begin
            dff_if_valid_q    <= if_valid;
            dff_wb_valid_q    <= wb_valid;
            if (if_pc_load) begin
                dff_if_pc_q <= if_pc;
            end
            if (wb_pc_load) begin
                dff_wb_pc_q <= wb_pc;
            end
            rff_instret_hit_q <= instret_bp_en & (minstret == instret_bp);
        end
    end

    for (genvar g = 0; g < N_IF; g++) begin : g_if_cmp
        orv64_trig_cmp #(
            .VADDR_W (VADDR_W),
            .CNT_W   (CNT_W)
        ) u_cmp (
            .clk          (clk),
            .rst          (rst),
            .pc_i         (dff_if_pc_q),
            .valid_i      (dff_if_valid_q),
            .en_i         (if_trig_en[g]),
            .addr_i       (if_trig_addr[g*VADDR_W +: VADDR_W]),
            .mask_i       (if_trig_mask[g*VADDR_W +: VADDR_W]),
            .cnt_inc_en_i (cnt_inc_en),
            .cnt_clr_i    (cnt_clr),
            .hit_o        (if_hit[g]),
            .cnt_o        (hit_cnt[g*CNT_W +: CNT_W])
        );
    end

    for (genvar g = 0; g < N_WB; g++) begin : g_wb_cmp
        orv64_trig_cmp #(
            .VADDR_W (VADDR_W),
            .CNT_W   (CNT_W)
        ) u_cmp (
            .clk          (clk),
            .rst          (rst),
            .pc_i         (dff_wb_pc_q),
            .valid_i      (dff_wb_valid_q),
            .en_i         (wb_trig_en[g]),
            .addr_i       (wb_trig_addr[g*VADDR_W +: VADDR_W]),
            .mask_i       (wb_trig_mask[g*VADDR_W +: VADDR_W]),
            .cnt_inc_en_i (cnt_inc_en),
            .cnt_clr_i    (cnt_clr),
            .hit_o        (wb_hit[g]),
            .cnt_o        (hit_cnt[(N_IF+g)*CNT_W +: CNT_W])
        );
    end

    assign any_hit = (|if_hit) | (|wb_hit) | rff_instret_hit_q;

    // Priority encode: IF over WB over instret, lowest index wins (scan high-to-low, last write sticks).
    always_comb begin
        hit_src = ORV64_TRIG_SRC_INSTRET;
        hit_idx = '0;
        for (int i = N_WB - 1; i >= 0; i--) begin
            if (wb_hit[i]) begin
                hit_src = ORV64_TRIG_SRC_WB;
                hit_idx = ORV64_TRIG_IDX_W'(i);
            end
        end
        for (int i = N_IF - 1; i >= 0; i--) begin
            if (if_hit[i]) begin
                hit_src = ORV64_TRIG_SRC_IF;
                hit_idx = ORV64_TRIG_IDX_W'(i);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ORV64_TRIG_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: SKIP waits for one retire so the halting instruction is stepped over.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ORV64_TRIG_RUN:  if (any_hit)        state_d = ORV64_TRIG_HALT;
            ORV64_TRIG_HALT: if (resume_req)     state_d = ORV64_TRIG_SKIP;
            ORV64_TRIG_SKIP: if (dff_wb_valid_q) state_d = ORV64_TRIG_RUN;
            default:                             state_d = ORV64_TRIG_RUN;
        endcase
    end

    // FSM outputs: stall is raw on the hit in RUN and drops in the resume-ack cycle.
    always_comb begin
        bp_stall   = 1'b0;
        halted     = 1'b0;
        resume_ack = 1'b0;
        cause_load = 1'b0;
        cnt_inc_en = 1'b0;
        case (state_q)
            ORV64_TRIG_RUN: begin
                bp_stall   = any_hit;
                cause_load = any_hit;
                cnt_inc_en = 1'b1;
            end
            ORV64_TRIG_HALT: begin
                halted     = 1'b1;
                bp_stall   = ~resume_req;
                resume_ack = resume_req;
            end
            default: begin
                bp_stall   = 1'b0;
            end
        endcase
    end

    // Cause registers survive resume and are only overwritten on the next halt entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            cause_vld_q <= 1'b0;
            cause_src_q <= ORV64_TRIG_SRC_IF;
            cause_idx_q <= '0;
        end else if (cause_load) begin
            cause_vld_q <= 1'b1;
            cause_src_q <= hit_src;
            cause_idx_q <= hit_idx;
        end
    end

    assign cause_vld = cause_vld_q;
    assign cause_src = cause_src_q;
    assign cause_idx = cause_idx_q;

endmodule

// File: tb/tb_orv64_trigger_unit.sv
// tb/tb_orv64_trigger_unit.sv - self-checking bench for orv64_trigger_unit
module tb_orv64_trigger_unit;

    localparam int N_IF = 4;
    localparam int N_WB = 4;
    localparam int VW   = 39;
    localparam int DW   = 64;
    localparam int CW   = 8;
    localparam int NT   = N_IF + N_WB;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_IF*VW-1:0]   if_trig_addr, if_trig_mask;
    logic [N_IF-1:0]      if_trig_en;
    logic [N_WB*VW-1:0]   wb_trig_addr, wb_trig_mask;
    logic [N_WB-1:0]      wb_trig_en;
    logic                 instret_bp_en;
    logic [DW-1:0]        instret_bp, minstret;
    logic [VW-1:0]        if_pc, wb_pc;
    logic                 if_valid, wb_valid, resume_req, cnt_clr;
    logic                 resume_ack, bp_stall, halted, cause_vld;
    logic [1:0]           cause_src;
    logic [2:0]           cause_idx;
    logic [NT*CW-1:0]     hit_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model: sampled pipeline values, halt/step-over flags, cause, counters.
    bit          m_vif, m_vwb, m_inst;
    logic [VW-1:0] m_pcif, m_pcwb;
    bit          m_halt, m_skip, m_cvld;
    int          m_csrc, m_cidx;
    int          m_cnt [NT];
    bit          mh [NT];
    bit          mh_any;
    bit          e_stall, e_ack;

    always #5 clk = ~clk;

    orv64_trigger_unit #(
        .N_IF(N_IF), .N_WB(N_WB), .VADDR_W(VW), .DATA_W(DW), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .if_trig_addr(if_trig_addr), .if_trig_mask(if_trig_mask), .if_trig_en(if_trig_en),
        .wb_trig_addr(wb_trig_addr), .wb_trig_mask(wb_trig_mask), .wb_trig_en(wb_trig_en),
        .instret_bp_en(instret_bp_en), .instret_bp(instret_bp),
        .if_pc(if_pc), .wb_pc(wb_pc), .if_valid(if_valid), .wb_valid(wb_valid),
        .minstret(minstret), .resume_req(resume_req), .resume_ack(resume_ack),
        .cnt_clr(cnt_clr), .bp_stall(bp_stall), .halted(halted),
        .cause_vld(cause_vld), .cause_src(cause_src), .cause_idx(cause_idx),
        .hit_cnt(hit_cnt)
    );

    task automatic calc_hits();
        mh_any = m_inst;
        for (int i = 0; i < NT; i++) begin
            if (i < N_IF)
                mh[i] = m_vif && if_trig_en[i] &&
                        (((m_pcif ^ if_trig_addr[i*VW +: VW]) & if_trig_mask[i*VW +: VW]) == 0);
            else
                mh[i] = m_vwb && wb_trig_en[i-N_IF] &&
                        (((m_pcwb ^ wb_trig_addr[(i-N_IF)*VW +: VW]) & wb_trig_mask[(i-N_IF)*VW +: VW]) == 0);
            mh_any = mh_any | mh[i];
        end
    endtask

    function automatic logic [NT*CW-1:0] exp_cnt();
        logic [NT*CW-1:0] v;
        for (int i = 0; i < NT; i++) v[i*CW +: CW] = CW'(m_cnt[i]);
        return v;
    endfunction

    // Advance one clock: update the model from the inputs about to be sampled, then wait past the edge.
    task automatic step();
        bit running;
        calc_hits();
        running = !m_halt && !m_skip;
        if (rst) begin
            m_vif = 0; m_vwb = 0; m_inst = 0; m_pcif = '0; m_pcwb = '0;
            m_halt = 0; m_skip = 0; m_cvld = 0; m_csrc = 0; m_cidx = 0;
            for (int i = 0; i < NT; i++) m_cnt[i] = 0;
        end else begin
            for (int i = 0; i < NT; i++) begin
                if (cnt_clr) m_cnt[i] = 0;
                else if (running && mh[i] && m_cnt[i] < (1 << CW) - 1) m_cnt[i]++;
            end
            if (running && mh_any) begin
                m_halt = 1; m_cvld = 1; m_csrc = 2; m_cidx = 0;
                for (int i = 0; i < NT; i++) begin
                    if (mh[i]) begin
                        m_csrc = (i < N_IF) ? 0 : 1;
                        m_cidx = (i < N_IF) ? i : i - N_IF;
                        break;
                    end
                end
            end else if (m_halt && resume_req) begin
                m_halt = 0; m_skip = 1;
            end else if (m_skip && m_vwb) begin
                m_skip = 0;
            end
            m_vif = if_valid;
            m_vwb = wb_valid;
            if (if_valid && (|if_trig_en)) m_pcif = if_pc;
            if (wb_valid && (|wb_trig_en)) m_pcwb = wb_pc;
            m_inst = instret_bp_en && (minstret == instret_bp);
        end
        @(posedge clk);
        #1;
        calc_hits();
        e_stall = (!m_halt && !m_skip && mh_any) || (m_halt && !resume_req);
        e_ack   = m_halt && resume_req;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        if_trig_en = '0; wb_trig_en = '0; instret_bp_en = 1'b0;
        if_valid = 1'b0; wb_valid = 1'b0; resume_req = 1'b0; cnt_clr = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic release_halt();
        if_trig_en = '0; wb_trig_en = '0; instret_bp_en = 1'b0;
        if_valid = 1'b0; wb_valid = 1'b0;
        resume_req = 1'b1; step();
        resume_req = 1'b0; wb_valid = 1'b1; step();
        wb_valid = 1'b0; step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bp_stall !== 1'b0) begin failures++; $display("FAIL reset_bp_stall got=%0b exp=0", bp_stall); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%0b exp=0", halted); end
        checks++; if (cause_vld !== 1'b0) begin failures++; $display("FAIL reset_cause_vld got=%0b exp=0", cause_vld); end
        checks++; if (resume_ack !== 1'b0) begin failures++; $display("FAIL reset_resume_ack got=%0b exp=0", resume_ack); end
        checks++; if (hit_cnt !== '0) begin failures++; $display("FAIL reset_hit_cnt got=%h exp=0", hit_cnt); end
    endtask

    task automatic test_if_exact();
        do_reset();
        if_trig_en = 4'b0001; if_trig_addr[0 +: VW] = 39'h1000; if_trig_mask[0 +: VW] = '1;
        if_pc = 39'h1000; if_valid = 1'b1;
        step();
        checks++; if (bp_stall !== 1'b1) begin failures++; $display("FAIL if_exact_stall got=%0b exp=1", bp_stall); end
        if_valid = 1'b0;
        step();
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL if_exact_halted got=%0b exp=1", halted); end
        checks++; if (cause_vld !== 1'b1 || cause_src !== 2'd0 || cause_idx !== 3'd0) begin failures++;
            $display("FAIL if_exact_cause got=%0b/%0d/%0d exp=1/0/0", cause_vld, cause_src, cause_idx); end
        checks++; if (hit_cnt[0 +: CW] !== 8'd1) begin failures++; $display("FAIL if_exact_cnt got=%0d exp=1", hit_cnt[0 +: CW]); end
        release_halt();
        checks++; if (halted !== 1'b0 || bp_stall !== 1'b0) begin failures++;
            $display("FAIL if_exact_resumed got=%0b/%0b exp=0/0", halted, bp_stall); end
    endtask

    task automatic test_wb_mask();
        do_reset();
        wb_trig_en = 4'b0100; wb_trig_addr[2*VW +: VW] = 39'h2000; wb_trig_mask[2*VW +: VW] = {{(VW-8){1'b1}}, 8'h00};
        wb_pc = 39'h2100; wb_valid = 1'b1;
        step();
        checks++; if (bp_stall !== 1'b0) begin failures++; $display("FAIL wb_mask_nohit got=%0b exp=0", bp_stall); end
        wb_pc = 39'h20A4;
        step();
        checks++; if (bp_stall !== 1'b1) begin failures++; $display("FAIL wb_mask_hit got=%0b exp=1", bp_stall); end
        wb_valid = 1'b0;
        step();
        checks++; if (cause_src !== 2'd1 || cause_idx !== 3'd2) begin failures++;
            $display("FAIL wb_mask_cause got=%0d/%0d exp=1/2", cause_src, cause_idx); end
        release_halt();
    endtask

    task automatic test_same_cycle();
        do_reset();
        if_trig_en = 4'b0010; if_trig_addr[1*VW +: VW] = 39'h1000; if_trig_mask[1*VW +: VW] = '1;
        wb_trig_en = 4'b0001; wb_trig_addr[0 +: VW] = 39'h2000; wb_trig_mask[0 +: VW] = '1;
        if_pc = 39'h1000; wb_pc = 39'h2000; if_valid = 1'b1; wb_valid = 1'b1;
        step();
        if_valid = 1'b0; wb_valid = 1'b0;
        step();
        checks++; if (cause_src !== 2'd0 || cause_idx !== 3'd1) begin failures++;
            $display("FAIL same_cycle_cause got=%0d/%0d exp=0/1", cause_src, cause_idx); end
        checks++; if (hit_cnt[1*CW +: CW] !== 8'd1 || hit_cnt[4*CW +: CW] !== 8'd1) begin failures++;
            $display("FAIL same_cycle_cnt got=%0d/%0d exp=1/1", hit_cnt[1*CW +: CW], hit_cnt[4*CW +: CW]); end
        release_halt();
    endtask

    task automatic test_instret();
        do_reset();
        instret_bp = 64'd100; instret_bp_en = 1'b1; minstret = 64'd100;
        step();
        checks++; if (bp_stall !== 1'b1) begin failures++; $display("FAIL instret_stall got=%0b exp=1", bp_stall); end
        step();
        checks++; if (halted !== 1'b1 || cause_src !== 2'd2 || cause_idx !== 3'd0) begin failures++;
            $display("FAIL instret_cause got=%0b/%0d/%0d exp=1/2/0", halted, cause_src, cause_idx); end
        resume_req = 1'b1;
        #1;
        checks++; if (resume_ack !== 1'b1 || bp_stall !== 1'b0) begin failures++;
            $display("FAIL instret_ack got=%0b/%0b exp=1/0", resume_ack, bp_stall); end
        step();
        resume_req = 1'b0;
        #1;
        checks++; if (resume_ack !== 1'b0 || halted !== 1'b0) begin failures++;
            $display("FAIL instret_ack_pulse got=%0b/%0b exp=0/0", resume_ack, halted); end
        minstret = 64'd101; wb_valid = 1'b1;
        step();
        wb_valid = 1'b0;
        step();
        step();
        checks++; if (bp_stall !== 1'b0 || halted !== 1'b0 || cause_vld !== 1'b1) begin failures++;
            $display("FAIL instret_rearm got=%0b/%0b/%0b exp=0/0/1", bp_stall, halted, cause_vld); end
        instret_bp_en = 1'b0;
    endtask

    task automatic test_saturate();
        int guard;
        do_reset();
        if_trig_en = 4'b0001; if_trig_mask[0 +: VW] = '0; if_trig_addr[0 +: VW] = 39'h1234;
        if_pc = 39'h5678; if_valid = 1'b1; resume_req = 1'b1; wb_valid = 1'b1;
        for (int c = 0; c < 800; c++) step();
        checks++; if (hit_cnt[0 +: CW] !== 8'hFF) begin failures++; $display("FAIL sat_cnt got=%0d exp=255", hit_cnt[0 +: CW]); end
        guard = 0;
        while (!(!m_halt && !m_skip && mh_any) && guard < 8) begin step(); guard++; end
        checks++; if (guard >= 8) begin failures++; $display("FAIL sat_find_hit got=timeout exp=run_hit"); end
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        checks++; if (hit_cnt[0 +: CW] !== 8'h00) begin failures++; $display("FAIL clr_priority got=%0d exp=0", hit_cnt[0 +: CW]); end
        resume_req = 1'b0; if_valid = 1'b0; wb_valid = 1'b0;
    endtask

    task automatic test_rst_halt();
        do_reset();
        if_trig_en = 4'b0001; if_trig_addr[0 +: VW] = 39'h1000; if_trig_mask[0 +: VW] = '1;
        if_pc = 39'h1000; if_valid = 1'b1;
        step();
        if_valid = 1'b0;
        step();
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL rst_halt_pre got=%0b exp=1", halted); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (bp_stall !== 1'b0 || halted !== 1'b0 || cause_vld !== 1'b0) begin failures++;
            $display("FAIL rst_halt_post got=%0b/%0b/%0b exp=0/0/0", bp_stall, halted, cause_vld); end
        checks++; if (hit_cnt !== '0) begin failures++; $display("FAIL rst_halt_cnt got=%h exp=0", hit_cnt); end
    endtask

    task automatic test_random();
        logic [VW-1:0] pcs [4];
        logic [VW-1:0] msk [4];
        pcs[0] = 39'h1000; pcs[1] = 39'h1004; pcs[2] = 39'h2000; pcs[3] = 39'h20A4;
        msk[0] = '1; msk[1] = {{(VW-8){1'b1}}, 8'h00}; msk[2] = '0; msk[3] = {{(VW-4){1'b1}}, 4'h0};
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 16 == 0) begin
                for (int i = 0; i < N_IF; i++) begin
                    if_trig_addr[i*VW +: VW] = pcs[$urandom_range(0, 3)];
                    if_trig_mask[i*VW +: VW] = msk[$urandom_range(0, 3)];
                end
                for (int i = 0; i < N_WB; i++) begin
                    wb_trig_addr[i*VW +: VW] = pcs[$urandom_range(0, 3)];
                    wb_trig_mask[i*VW +: VW] = msk[$urandom_range(0, 3)];
                end
                if_trig_en    = 4'($urandom);
                wb_trig_en    = 4'($urandom);
                instret_bp_en = 1'($urandom);
                instret_bp    = 64'($urandom_range(0, 3));
            end
            if_pc      = pcs[$urandom_range(0, 3)];
            wb_pc      = pcs[$urandom_range(0, 3)];
            if_valid   = ($urandom_range(0, 2) == 0);
            wb_valid   = ($urandom_range(0, 1) == 0);
            minstret   = 64'($urandom_range(0, 3));
            resume_req = ($urandom_range(0, 3) == 0);
            cnt_clr    = ($urandom_range(0, 40) == 0);
            rst        = ($urandom_range(0, 150) == 0);
            step();
            checks++; if (bp_stall !== e_stall) begin failures++; $display("FAIL rnd_stall cyc=%0d got=%0b exp=%0b", c, bp_stall, e_stall); end
            checks++; if (resume_ack !== e_ack) begin failures++; $display("FAIL rnd_ack cyc=%0d got=%0b exp=%0b", c, resume_ack, e_ack); end
            checks++; if (halted !== m_halt) begin failures++; $display("FAIL rnd_halted cyc=%0d got=%0b exp=%0b", c, halted, m_halt); end
            checks++; if (cause_vld !== m_cvld) begin failures++; $display("FAIL rnd_cause_vld cyc=%0d got=%0b exp=%0b", c, cause_vld, m_cvld); end
            checks++; if (cause_src !== 2'(m_csrc)) begin failures++; $display("FAIL rnd_cause_src cyc=%0d got=%0d exp=%0d", c, cause_src, m_csrc); end
            checks++; if (cause_idx !== 3'(m_cidx)) begin failures++; $display("FAIL rnd_cause_idx cyc=%0d got=%0d exp=%0d", c, cause_idx, m_cidx); end
            checks++; if (hit_cnt !== exp_cnt()) begin failures++; $display("FAIL rnd_hit_cnt cyc=%0d got=%h exp=%h", c, hit_cnt, exp_cnt()); end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        if_trig_addr = '0; if_trig_mask = '0; if_trig_en = '0;
        wb_trig_addr = '0; wb_trig_mask = '0; wb_trig_en = '0;
        instret_bp_en = 1'b0; instret_bp = '0; minstret = '0;
        if_pc = '0; wb_pc = '0; if_valid = 1'b0; wb_valid = 1'b0;
        resume_req = 1'b0; cnt_clr = 1'b0;
        test_reset();
        test_if_exact();
        test_wb_mask();
        test_same_cycle();
        test_instret();
        test_saturate();
        test_rst_halt();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
